// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the memory port arbiter: FSM state encoding,
//   grant source select values and the timeout counter width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PT_ACCESS  = 2'd1,
    CPU_ACCESS = 2'd2,
    RESP       = 2'd3
  } arb_state_e;

  // Which requester owns the current access / response.
  localparam logic SRC_PT  = 1'b0;
  localparam logic SRC_CPU = 1'b1;

  // Bits needed to hold the values 0..cycles.
  function automatic int unsigned tmo_cnt_w(input int unsigned cycles);
    return $clog2(cycles + 32'd1);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr
//   Counts memory-request cycles that pass without an acknowledge.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     clear_i     restart the count (asserted on entry to an access)
//     enable_i    this cycle is a request cycle without acknowledge
//     expired_o   combinational: this is the TIMEOUT_CYCLES-th unacknowledged
//                 request cycle, so the access must be aborted at the next edge
module mem_timeout_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned      CNT_W = tmo_cnt_w(TIMEOUT_CYCLES);
  // cnt_q holds the number of waited cycles already completed, so the
  // current cycle is number cnt_q+1; expiry fires when that equals the limit.
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  // Wait-cycle counter, saturating at LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + ONE;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expired_o = enable_i & (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Merges MMU page-table reads and CPU data accesses onto one req/ack
//   memory port. Page-table walks have priority; a bus timeout aborts any
//   access whose acknowledge never arrives. All outputs are registered.
//   Ports:
//     pt_addr/pt_read            page-table read request (single-cycle pulse)
//     pt_data/pt_ready           PTE data, held; one-cycle completion pulse
//     cpu_addr/cpu_addr_ok/cpu_fault, cpu_read/cpu_write/cpu_wdata/cpu_be
//                                CPU level request with translation status
//     cpu_rdata/cpu_ready/cpu_err read data (held), completion pulse, error
//     mem_req/mem_we/mem_addr/mem_wdata/mem_be, mem_rdata/mem_ack
//                                memory port
//     bus_error                  one-cycle pulse when an access times out
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     pt_addr,
  input  logic                  pt_read,
  output logic [DATA_W-1:0]     pt_data,
  output logic                  pt_ready,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic                  cpu_addr_ok,
  input  logic                  cpu_fault,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [DATA_W/8-1:0]   cpu_be,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  bus_error
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_e          state_q;
  logic                src_q;
  logic                pt_pending_q;
  logic [ADDR_W-1:0]   pt_addr_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [BE_W-1:0]     mem_be_q;
  logic [DATA_W-1:0]   pt_data_q;
  logic                pt_ready_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic                cpu_ready_q;
  logic                cpu_err_q;
  logic                bus_error_q;

  logic cpu_req_s;
  logic pt_start_s;
  logic cpu_start_s;
  logic in_access_s;
  logic tmo_expired_s;

  assign cpu_req_s   = cpu_read | cpu_write;
  assign pt_start_s  = (state_q == IDLE) & (pt_pending_q | pt_read);
  assign cpu_start_s = (state_q == IDLE) & ~(pt_pending_q | pt_read) & cpu_req_s
                       & cpu_addr_ok & ~cpu_fault;
  assign in_access_s = (state_q == PT_ACCESS) | (state_q == CPU_ACCESS);

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (pt_start_s | cpu_start_s),
    .enable_i (in_access_s & ~mem_ack),
    .expired_o(tmo_expired_s)
  );

  // Arbitration FSM with its registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      src_q        <= SRC_PT;
      pt_pending_q <= 1'b0;
      pt_addr_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      pt_data_q    <= '0;
      pt_ready_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_ready_q  <= 1'b0;
      cpu_err_q    <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      pt_ready_q  <= 1'b0;
      cpu_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      bus_error_q <= 1'b0;
      // Every pulse is remembered; repeated pulses collapse into one walk.
      // The most recent pulse supplies the address.
      if (pt_read) begin
        pt_pending_q <= 1'b1;
        pt_addr_q    <= pt_addr;
      end else begin
        pt_pending_q <= pt_pending_q;
      end

      case (state_q)
        IDLE: begin
          if (pt_pending_q || pt_read) begin
            state_q      <= PT_ACCESS;
            src_q        <= SRC_PT;
            pt_pending_q <= 1'b0;
            mem_req_q    <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= pt_read ? pt_addr : pt_addr_q;
            mem_wdata_q  <= '0;
            mem_be_q     <= '1;
          end else if (cpu_req_s && cpu_addr_ok && cpu_fault) begin
            // Translation fault: answer at once, the memory is never touched.
            state_q     <= RESP;
            src_q       <= SRC_CPU;
            cpu_ready_q <= 1'b1;
            cpu_err_q   <= 1'b1;
          end else if (cpu_req_s && cpu_addr_ok) begin
            state_q     <= CPU_ACCESS;
            src_q       <= SRC_CPU;
            mem_req_q   <= 1'b1;
            mem_we_q    <= cpu_write;
            mem_addr_q  <= cpu_addr;
            mem_wdata_q <= cpu_wdata;
            mem_be_q    <= cpu_be;
          end else begin
            state_q <= IDLE;
          end
        end

        PT_ACCESS, CPU_ACCESS: begin
          // An acknowledge in the expiry cycle still completes normally.
          if (mem_ack) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            if (src_q == SRC_PT) begin
              pt_ready_q <= 1'b1;
              pt_data_q  <= mem_rdata;
            end else begin
              cpu_ready_q <= 1'b1;
              if (!mem_we_q) begin
                cpu_rdata_q <= mem_rdata;
              end else begin
                cpu_rdata_q <= cpu_rdata_q;
              end
            end
          end else if (tmo_expired_s) begin
            state_q     <= RESP;
            mem_req_q   <= 1'b0;
            bus_error_q <= 1'b1;
            if (src_q == SRC_PT) begin
              // A zero PTE is invalid, so the MMU turns this into a page fault.
              pt_ready_q <= 1'b1;
              pt_data_q  <= '0;
            end else begin
              cpu_ready_q <= 1'b1;
              cpu_err_q   <= 1'b1;
            end
          end else begin
            state_q <= state_q;
          end
        end

        RESP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign pt_data   = pt_data_q;
  assign pt_ready  = pt_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign cpu_err   = cpu_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign bus_error = bus_error_q;

endmodule
